// File: rtl/uart_rx_cmd_ctrl_pkg.sv
// Shared definitions for the UART command controllers: opcode bytes and the
// RX frame-parser state encoding.
package uart_rx_cmd_ctrl_pkg;

  localparam logic [7:0] CMD_RF_WR   = 8'hAA;
  localparam logic [7:0] CMD_RF_RD   = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_ADDR = 3'd1,
    ST_WR_DATA = 3'd2,
    ST_RD_ADDR = 3'd3,
    ST_ALU_OPA = 3'd4,
    ST_ALU_OPB = 3'd5,
    ST_ALU_FUN = 3'd6
  } rx_state_t;

endpackage

// File: rtl/uart_rx_cmd_ctrl.sv
// RX command controller: parses opcode frames from the UART byte stream into
// register-file and ALU strobes, all registered with one-cycle latency.
module uart_rx_cmd_ctrl
  import uart_rx_cmd_ctrl_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int FUN_W    = 4,
  parameter int OPA_ADDR = 0,
  parameter int OPB_ADDR = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_data_valid,
  input  logic [DATA_W-1:0] rx_p_data,
  output logic              rf_wr_en,
  output logic              rf_rd_en,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic              alu_en,
  output logic [FUN_W-1:0]  alu_fun,
  output logic              clk_gate_en,
  output logic              busy,
  output logic              cmd_err
);

  localparam logic [ADDR_W-1:0] W_OPA_ADDR = ADDR_W'(OPA_ADDR);
  localparam logic [ADDR_W-1:0] W_OPB_ADDR = ADDR_W'(OPB_ADDR);

  rx_state_t         r_state;
  logic [ADDR_W-1:0] r_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      rf_wr_en    <= 1'b0;
      rf_rd_en    <= 1'b0;
      rf_addr     <= '0;
      rf_wr_data  <= '0;
      alu_en      <= 1'b0;
      alu_fun     <= '0;
      clk_gate_en <= 1'b0;
      busy        <= 1'b0;
      cmd_err     <= 1'b0;
    end else begin
      rf_wr_en <= 1'b0;
      rf_rd_en <= 1'b0;
      alu_en   <= 1'b0;
      cmd_err  <= 1'b0;
      // Gate closes after the alu_en cycle unless a new ALU opcode reopens it below
      if (alu_en) clk_gate_en <= 1'b0;

      if (rx_data_valid) begin
        case (r_state)
          ST_IDLE: begin
            case (rx_p_data)
              CMD_RF_WR: begin
                r_state <= ST_WR_ADDR;
                busy    <= 1'b1;
              end
              CMD_RF_RD: begin
                r_state <= ST_RD_ADDR;
                busy    <= 1'b1;
              end
              CMD_ALU_OP: begin
                r_state     <= ST_ALU_OPA;
                busy        <= 1'b1;
                clk_gate_en <= 1'b1;
              end
              CMD_ALU_NOP: begin
                r_state     <= ST_ALU_FUN;
                busy        <= 1'b1;
                clk_gate_en <= 1'b1;
              end
              default: cmd_err <= 1'b1;
            endcase
          end
          ST_WR_ADDR: begin
            r_addr  <= rx_p_data[ADDR_W-1:0];
            r_state <= ST_WR_DATA;
          end
          ST_WR_DATA: begin
            rf_wr_en   <= 1'b1;
            rf_addr    <= r_addr;
            rf_wr_data <= rx_p_data;
            r_state    <= ST_IDLE;
            busy       <= 1'b0;
          end
          ST_RD_ADDR: begin
            rf_rd_en <= 1'b1;
            rf_addr  <= rx_p_data[ADDR_W-1:0];
            r_state  <= ST_IDLE;
            busy     <= 1'b0;
          end
          ST_ALU_OPA: begin
            rf_wr_en   <= 1'b1;
            rf_addr    <= W_OPA_ADDR;
            rf_wr_data <= rx_p_data;
            r_state    <= ST_ALU_OPB;
          end
          ST_ALU_OPB: begin
            rf_wr_en   <= 1'b1;
            rf_addr    <= W_OPB_ADDR;
            rf_wr_data <= rx_p_data;
            r_state    <= ST_ALU_FUN;
          end
          ST_ALU_FUN: begin
            alu_en  <= 1'b1;
            alu_fun <= rx_p_data[FUN_W-1:0];
            r_state <= ST_IDLE;
            busy    <= 1'b0;
          end
          default: begin
            r_state <= ST_IDLE;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cmd_ctrl.sv
// Randomized bench for uart_rx_cmd_ctrl: a frame-level reference model fills a
// scoreboard queue that a negedge monitor drains against the DUT strobes.
module tb_uart_rx_cmd_ctrl;
  import uart_rx_cmd_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_data_valid;
  logic [7:0] rx_p_data;
  logic       rf_wr_en, rf_rd_en, alu_en, clk_gate_en, busy, cmd_err;
  logic [3:0] rf_addr, alu_fun;
  logic [7:0] rf_wr_data;

  always #5 clk = ~clk;

  uart_rx_cmd_ctrl #(
    .DATA_W(8), .ADDR_W(4), .FUN_W(4), .OPA_ADDR(0), .OPB_ADDR(1)
  ) dut (
    .clk(clk), .rst(rst), .rx_data_valid(rx_data_valid), .rx_p_data(rx_p_data),
    .rf_wr_en(rf_wr_en), .rf_rd_en(rf_rd_en), .rf_addr(rf_addr), .rf_wr_data(rf_wr_data),
    .alu_en(alu_en), .alu_fun(alu_fun), .clk_gate_en(clk_gate_en), .busy(busy),
    .cmd_err(cmd_err)
  );

  typedef struct {
    bit         wr, rd, alu, err;
    logic [3:0] addr;
    logic [7:0] data;
    logic [3:0] fun;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] frame[$];
  bit         m_rst = 1'b0;
  bit         m_alu_done = 1'b0;
  int         checks = 0;
  int         errors = 0;

  function automatic int frame_len(input logic [7:0] op);
    case (op)
      CMD_RF_WR:   return 3;
      CMD_RF_RD:   return 2;
      CMD_ALU_OP:  return 4;
      CMD_ALU_NOP: return 2;
      default:     return 0;
    endcase
  endfunction

  // Reference model: accumulate frame bytes, emit the strobe each byte implies.
  always @(posedge clk) begin : model
    ev_t        e;
    logic [7:0] b;
    m_alu_done = 1'b0;
    m_rst      = rst;
    e          = '{default: 0};
    if (rst) begin
      frame.delete();
    end else if (rx_data_valid) begin
      b = rx_p_data;
      if (frame.size() == 0) begin
        if (frame_len(b) != 0) frame.push_back(b);
        else begin
          e.err = 1;
          exp_q.push_back(e);
        end
      end else begin
        frame.push_back(b);
        if (frame[0] == CMD_RF_WR && frame.size() == 3) begin
          e.wr = 1; e.addr = b_lo(frame[1]); e.data = frame[2];
          exp_q.push_back(e);
        end else if (frame[0] == CMD_RF_RD) begin
          e.rd = 1; e.addr = b_lo(frame[1]);
          exp_q.push_back(e);
        end else if (frame[0] == CMD_ALU_OP && frame.size() < 4) begin
          e.wr = 1; e.addr = 4'(frame.size() - 2); e.data = b;
          exp_q.push_back(e);
        end else if (frame[0] == CMD_ALU_OP || frame[0] == CMD_ALU_NOP) begin
          e.alu = 1; e.fun = b_lo(b);
          exp_q.push_back(e);
          m_alu_done = 1'b1;
        end
        if (frame.size() == frame_len(frame[0])) frame.delete();
      end
    end
  end

  function automatic logic [3:0] b_lo(input logic [7:0] v);
    return v[3:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: per-cycle status plus in-order scoreboard of strobes.
  always @(negedge clk) begin : monitor
    ev_t  e;
    bit   frame_open, alu_open;
    logic [3:0] got;
    frame_open = (frame.size() != 0);
    alu_open   = frame_open && (frame[0] == CMD_ALU_OP || frame[0] == CMD_ALU_NOP);
    got = {rf_wr_en, rf_rd_en, alu_en, cmd_err};
    chk("strobe_exclusive", 32'(int'(rf_wr_en) + int'(rf_rd_en) + int'(alu_en) > 1), 32'd0);
    if (m_rst)
      chk("reset_outputs", {rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, alu_en, alu_fun,
                            clk_gate_en, busy, cmd_err}, 32'd0);
    chk("busy", 32'(busy), 32'(frame_open));
    chk("clk_gate_en", 32'(clk_gate_en), 32'(alu_open || m_alu_done));
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("strobes", 32'(got), 32'({e.wr, e.rd, e.alu, e.err}));
      if (e.wr) begin
        chk("wr_addr", 32'(rf_addr), 32'(e.addr));
        chk("wr_data", 32'(rf_wr_data), 32'(e.data));
      end
      if (e.rd) chk("rd_addr", 32'(rf_addr), 32'(e.addr));
      if (e.alu) chk("alu_fun", 32'(alu_fun), 32'(e.fun));
    end else if (got != 4'd0) begin
      chk("unexpected_strobe", 32'(got), 32'd0);
    end
  end

  task automatic send(input logic [7:0] b, input int gap);
    rx_data_valid = 1'b1;
    rx_p_data     = b;
    @(posedge clk); #1;
    rx_data_valid = 1'b0;
    rx_p_data     = 8'($urandom);
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [7:0] b;
    int         kind, gap;
    rst = 1'b1;
    rx_data_valid = 1'b0;
    rx_p_data = 8'h00;
    idle(3);
    rst = 1'b0;
    idle(2);

    send(8'hAA, 1); send(8'h05, 0); send(8'h3C, 3);
    send(8'hBB, 2); send(8'h1A, 3);
    send(8'hCC, 1); send(8'h12, 1); send(8'h34, 0); send(8'h02, 3);
    send(8'h7F, 2); send(8'hDD, 1); send(8'h03, 3);
    send(8'hAA, 0); send(8'h02, 0); send(8'hAA, 0); send(8'hBB, 0); send(8'h04, 3);
    send(8'hCC, 0); send(8'h12, 1); pulse_rst(); idle(1);
    send(8'hBB, 0); send(8'h01, 3);
    send(8'hDD, 0); send(8'h0F, 0); send(8'hCC, 0); send(8'hCC, 0); send(8'hDD, 0);
    send(8'hFE, 3);

    for (int i = 0; i < 400; i++) begin
      kind = int'($urandom_range(0, 5));
      gap  = int'($urandom_range(0, 2));
      case (kind)
        0: begin send(CMD_RF_WR, gap); send(8'($urandom), gap); send(8'($urandom), gap); end
        1: begin send(CMD_RF_RD, gap); send(8'($urandom), gap); end
        2: begin
          send(CMD_ALU_OP, gap);
          repeat (3) send(8'($urandom), gap);
        end
        3: begin send(CMD_ALU_NOP, gap); send(8'($urandom), gap); end
        4: begin
          do b = 8'($urandom); while (frame_len(b) != 0);
          send(b, gap);
        end
        default: begin
          send(CMD_ALU_OP, gap);
          repeat (int'($urandom_range(0, 2))) send(8'($urandom), gap);
          pulse_rst();
        end
      endcase
    end

    idle(5);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
